msrv32_pc_controller: RTL

- Sequences the program counter register of the RV32I core.
- Computes the next-PC value fed into the PC register's mux input each cycle: reset vector, PC+4, branch/jump target, trap vector or mret return address.
- Runs the instruction-fetch handshake, holds the PC on stalls and memory wait, and issues a pipeline flush on every redirect.
- Sits between the PC register, the branch/trap logic and the instruction memory port.

---
 rtl/msrv32_pc_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/msrv32_pc_controller.sv
// Program-counter sequencer for the RV32I core: selects the next PC, runs the
// instruction-fetch handshake and raises a one-cycle flush on every redirect.
module msrv32_pc_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY   = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic [31:0] pc_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        stall_in,
    input  logic        imem_ready_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_mux_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic [31:0] fetch_count_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_FETCH    = 2'd1,
        S_STALL    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  boot_cnt_r;
    logic        flush_r;
    logic        misaligned_r;
    logic [31:0] fetch_count_r;

    logic [31:0] pc_mux_s;
    logic        imem_req_s;
    logic        count_inc_s;
    logic        misaligned_next_s;
    logic [31:0] trap_target_s;
    logic [31:0] epc_target_s;
    logic        branch_ok_s;
    logic        branch_mis_s;

    // Redirect targets are forced word-aligned; branch alignment decides redirect vs. pulse.
    assign trap_target_s = {trap_vector_in[31:2], 2'b00};
    assign epc_target_s  = {epc_in[31:2], 2'b00};
    assign branch_ok_s   = branch_taken_in && !stall_in && (branch_target_in[1:0] == 2'b00);
    assign branch_mis_s  = branch_taken_in && !stall_in && (branch_target_in[1:0] != 2'b00);

    // Next-state and next-PC selection.
    always_comb begin
        next_state_s      = state_r;
        pc_mux_s          = pc_in;
        imem_req_s        = 1'b0;
        count_inc_s       = 1'b0;
        misaligned_next_s = 1'b0;
        case (state_r)
            S_BOOT: begin
                pc_mux_s = RESET_VECTOR;
                if (boot_cnt_r == BOOT_LAST) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_BOOT;
                end
            end
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (trap_taken_in) begin
                    pc_mux_s     = trap_target_s;
                    next_state_s = S_REDIRECT;
                end else if (mret_in) begin
                    pc_mux_s     = epc_target_s;
                    next_state_s = S_REDIRECT;
                end else if (branch_ok_s) begin
                    pc_mux_s     = branch_target_in;
                    next_state_s = S_REDIRECT;
                end else begin
                    // A misaligned branch only flags; the fetch proceeds as if untaken.
                    misaligned_next_s = branch_mis_s;
                    if (stall_in) begin
                        next_state_s = S_STALL;
                    end else if (imem_ready_in) begin
                        pc_mux_s     = pc_in + 32'd4;
                        count_inc_s  = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
            end
            S_STALL: begin
                if (trap_taken_in) begin
                    pc_mux_s     = trap_target_s;
                    next_state_s = S_REDIRECT;
                end else if (mret_in) begin
                    pc_mux_s     = epc_target_s;
                    next_state_s = S_REDIRECT;
                end else if (stall_in) begin
                    next_state_s = S_STALL;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_REDIRECT: begin
                if (trap_taken_in) begin
                    pc_mux_s     = trap_target_s;
                    next_state_s = S_REDIRECT;
                end else if (mret_in) begin
                    pc_mux_s     = epc_target_s;
                    next_state_s = S_REDIRECT;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            default: begin
                pc_mux_s     = RESET_VECTOR;
                next_state_s = S_BOOT;
            end
        endcase
    end

    // State, boot counter, flush/misaligned pulses and fetch counter.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_r       <= S_BOOT;
            boot_cnt_r    <= 8'd0;
            flush_r       <= 1'b0;
            misaligned_r  <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            state_r      <= next_state_s;
            boot_cnt_r   <= (state_r == S_BOOT) ? boot_cnt_r + 8'd1 : 8'd0;
            flush_r      <= (next_state_s == S_REDIRECT);
            misaligned_r <= misaligned_next_s;
            if (count_inc_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
        end
    end

    assign imem_req_out    = imem_req_s;
    assign imem_addr_out   = pc_in;
    assign pc_mux_out      = pc_mux_s;
    assign flush_out       = flush_r;
    assign misaligned_out  = misaligned_r;
    assign fetch_count_out = fetch_count_r;
    assign state_out       = state_r;

endmodule
